// File: rtl/lc3b_types.sv
// Shared types and defaults for the LC-3b memory hierarchy (victim cache slice).
package lc3b_types;

    localparam int unsigned VIC_ENTRIES = 4;
    localparam int unsigned VIC_LINE_W  = 128;

    typedef enum logic [2:0] {
        VIC_IDLE,
        VIC_LOOKUP,
        VIC_FETCH,
        VIC_RESP,
        VIC_WB,
        VIC_INSERT
    } lc3b_vic_state;

endpackage

// File: rtl/victim_cache_nway_lru.sv
// True-LRU age tracker: MRU has age 0, ages always form a permutation of 0..ENTRIES-1.
module victim_lru_age #(
    parameter int unsigned ENTRIES = 4,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] lru_idx
);

    logic [IDX_W-1:0] age_q [ENTRIES];
    logic [IDX_W-1:0] age_d [ENTRIES];

    // Touched entry becomes MRU; entries younger than it age by one.
    always_comb begin
        age_d = age_q;
        if (touch) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = IDX_W'(age_q[i] + 1'b1);
                end
            end
            age_d[touch_idx] = '0;
        end
    end

    // The oldest entry is the replacement victim.
    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_q[i] == IDX_W'(ENTRIES - 1)) begin
                lru_idx = IDX_W'(i);
            end
        end
    end

    // Age registers; reset ordering makes entry 0 MRU and the last entry LRU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/victim_cache_nway.sv
// N-entry fully-associative victim cache with dirty write-back between L1 and memory.
module victim_cache_nway
    import lc3b_types::*;
#(
    parameter int unsigned ENTRIES = VIC_ENTRIES,
    parameter int unsigned LINE_W  = VIC_LINE_W,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned OFF_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              evict_valid,
    output logic              evict_ready,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    input  logic              evict_dirty,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              resp_dirty,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;

    lc3b_vic_state state_q, state_d;

    logic [TAG_W-1:0]  tag_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_d  [ENTRIES];
    logic [LINE_W-1:0] data_q [ENTRIES];
    logic [LINE_W-1:0] data_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;

    logic [TAG_W-1:0]  ev_tag_q, ev_tag_d, req_tag_q, req_tag_d;
    logic [LINE_W-1:0] ev_data_q, ev_data_d;
    logic              ev_dirty_q, ev_dirty_d;
    logic [IDX_W-1:0]  slot_q, slot_d;

    logic              evict_ready_q, evict_ready_d, req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic              resp_dirty_q, resp_dirty_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d, pmem_wdata_q, pmem_wdata_d;
    logic              pmem_read_q, pmem_read_d, pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;

    logic [TAG_W-1:0]  ev_tag_c;
    logic              ev_hit_c, free_c, lk_hit_c, touch_c;
    logic [IDX_W-1:0]  ev_idx_c, free_idx_c, lk_idx_c, lru_idx_c;
    logic              unused_addr_bits;

    assign ev_tag_c         = evict_addr[ADDR_W-1:OFF_W];
    assign unused_addr_bits = ^{evict_addr[OFF_W-1:0], req_addr[OFF_W-1:0]};

    victim_lru_age #(.ENTRIES(ENTRIES)) u_lru (
        .clk       (clk),
        .reset_n   (reset_n),
        .touch     (touch_c),
        .touch_idx (slot_q),
        .lru_idx   (lru_idx_c)
    );

    // Parallel CAM compares for the incoming victim and the registered lookup tag.
    always_comb begin
        ev_hit_c   = 1'b0;
        ev_idx_c   = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        lk_hit_c   = 1'b0;
        lk_idx_c   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == ev_tag_c) begin
                ev_hit_c = 1'b1;
                ev_idx_c = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == req_tag_q) begin
                lk_hit_c = 1'b1;
                lk_idx_c = IDX_W'(i);
            end
        end
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // Next-state, storage update and registered-output decode.
    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        data_d         = data_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        ev_tag_d       = ev_tag_q;
        ev_data_d      = ev_data_q;
        ev_dirty_d     = ev_dirty_q;
        slot_d         = slot_q;
        req_tag_d      = req_tag_q;
        resp_data_d    = resp_data_q;
        resp_hit_d     = resp_hit_q;
        resp_dirty_d   = resp_dirty_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        touch_c        = 1'b0;

        case (state_q)
            VIC_IDLE: begin
                if (evict_valid) begin
                    ev_tag_d   = ev_tag_c;
                    ev_data_d  = evict_data;
                    ev_dirty_d = evict_dirty | (ev_hit_c & dirty_q[ev_idx_c]);
                    state_d    = VIC_INSERT;
                    if (ev_hit_c) begin
                        slot_d = ev_idx_c;
                    end else if (free_c) begin
                        slot_d = free_idx_c;
                    end else begin
                        slot_d = lru_idx_c;
                        if (dirty_q[lru_idx_c]) begin
                            pmem_address_d = {tag_q[lru_idx_c], {OFF_W{1'b0}}};
                            pmem_wdata_d   = data_q[lru_idx_c];
                            state_d        = VIC_WB;
                        end
                    end
                end else if (req_valid) begin
                    req_tag_d = req_addr[ADDR_W-1:OFF_W];
                    state_d   = VIC_LOOKUP;
                end
            end
            VIC_LOOKUP: begin
                if (lk_hit_c) begin
                    resp_data_d       = data_q[lk_idx_c];
                    resp_hit_d        = 1'b1;
                    resp_dirty_d      = dirty_q[lk_idx_c];
                    valid_d[lk_idx_c] = 1'b0;
                    state_d           = VIC_RESP;
                end else begin
                    pmem_address_d = {req_tag_q, {OFF_W{1'b0}}};
                    state_d        = VIC_FETCH;
                end
            end
            VIC_FETCH: begin
                if (pmem_resp) begin
                    resp_data_d  = pmem_rdata;
                    resp_hit_d   = 1'b0;
                    resp_dirty_d = 1'b0;
                    state_d      = VIC_RESP;
                end
            end
            VIC_RESP: begin
                state_d = VIC_IDLE;
            end
            VIC_WB: begin
                if (pmem_resp) begin
                    state_d = VIC_INSERT;
                end
            end
            VIC_INSERT: begin
                tag_d[slot_q]   = ev_tag_q;
                data_d[slot_q]  = ev_data_q;
                valid_d[slot_q] = 1'b1;
                dirty_d[slot_q] = ev_dirty_q;
                touch_c         = 1'b1;
                state_d         = VIC_IDLE;
            end
            default: begin
                state_d = VIC_IDLE;
            end
        endcase

        evict_ready_d = (state_d == VIC_IDLE);
        req_ready_d   = (state_d == VIC_IDLE);
        resp_valid_d  = (state_d == VIC_RESP);
        pmem_read_d   = (state_d == VIC_FETCH);
        pmem_write_d  = (state_d == VIC_WB);
    end

    // State, storage and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= VIC_IDLE;
            tag_q          <= '{default: '0};
            data_q         <= '{default: '0};
            valid_q        <= '0;
            dirty_q        <= '0;
            ev_tag_q       <= '0;
            ev_data_q      <= '0;
            ev_dirty_q     <= 1'b0;
            slot_q         <= '0;
            req_tag_q      <= '0;
            evict_ready_q  <= 1'b0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_hit_q     <= 1'b0;
            resp_dirty_q   <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            ev_tag_q       <= ev_tag_d;
            ev_data_q      <= ev_data_d;
            ev_dirty_q     <= ev_dirty_d;
            slot_q         <= slot_d;
            req_tag_q      <= req_tag_d;
            evict_ready_q  <= evict_ready_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_hit_q     <= resp_hit_d;
            resp_dirty_q   <= resp_dirty_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    assign evict_ready  = evict_ready_q;
    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_hit     = resp_hit_q;
    assign resp_dirty   = resp_dirty_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_victim_cache_nway.sv
// Bench for victim_cache_nway: directed scenarios then random traffic against a recency-list model.
module tb_victim_cache_nway;

    localparam int unsigned N  = 4;
    localparam int unsigned LW = 128;
    localparam int unsigned AW = 16;
    localparam int unsigned TW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          evict_valid, evict_ready, evict_dirty;
    logic [AW-1:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid, resp_hit, resp_dirty;
    logic [LW-1:0] resp_data;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: entry contents plus a recency list (front = most recent).
    logic          m_valid [N];
    logic          m_dirty [N];
    logic [TW-1:0] m_tag   [N];
    logic [LW-1:0] m_data  [N];
    int            m_order [$];

    always #5 clk = ~clk;

    victim_cache_nway dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .evict_valid  (evict_valid),
        .evict_ready  (evict_ready),
        .evict_addr   (evict_addr),
        .evict_data   (evict_data),
        .evict_dirty  (evict_dirty),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_hit     (resp_hit),
        .resp_dirty   (resp_dirty),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_order = {};
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            m_order.push_back(i);
        end
    endtask

    task automatic model_touch(input int s);
        int pos = 0;
        foreach (m_order[k]) if (m_order[k] == s) pos = k;
        m_order.delete(pos);
        m_order.push_front(s);
    endtask

    function automatic int model_find(input logic [TW-1:0] t);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_evict_ready", evict_ready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_pmem_strobes", {pmem_read, pmem_write}, 0);
        chk("rst_resp_data", resp_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", {evict_ready, req_ready}, 2'b11);
        model_reset();
    endtask

    task automatic do_evict(input logic [AW-1:0] addr, input logic [LW-1:0] data,
                            input logic dirty, input int wb_delay);
        logic [TW-1:0] t;
        int            slot;
        logic          wb, new_dirty;
        logic [TW-1:0] wb_tag;
        logic [LW-1:0] wb_data;
        t         = addr[AW-1:4];
        slot      = model_find(t);
        new_dirty = dirty | ((slot >= 0) ? m_dirty[slot] : 1'b0);
        wb        = 1'b0;
        wb_tag    = '0;
        wb_data   = '0;
        if (slot < 0) for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) begin
            slot    = m_order[$];
            wb      = m_dirty[slot];
            wb_tag  = m_tag[slot];
            wb_data = m_data[slot];
        end
        evict_valid = 1'b1;
        evict_addr  = addr;
        evict_data  = data;
        evict_dirty = dirty;
        chk("ev_ready_idle", evict_ready, 1);
        @(negedge clk);
        evict_valid = 1'b0;
        chk("ev_ready_busy", {evict_ready, req_ready}, 0);
        chk("ev_pmem_read", pmem_read, 0);
        chk("ev_pmem_write", pmem_write, wb);
        if (wb) begin
            chk("wb_address", pmem_address, {wb_tag, 4'h0});
            chk("wb_wdata", pmem_wdata, wb_data);
            for (int k = 0; k < wb_delay; k++) begin
                @(negedge clk);
                chk("wb_hold", {pmem_write, pmem_read, evict_ready}, 3'b100);
            end
            pmem_resp = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b0;
            chk("wb_done_insert", {pmem_write, evict_ready}, 0);
        end
        @(negedge clk);
        chk("ev_ready_back", evict_ready, 1);
        m_tag[slot]   = t;
        m_data[slot]  = data;
        m_valid[slot] = 1'b1;
        m_dirty[slot] = new_dirty;
        model_touch(slot);
    endtask

    task automatic do_lookup(input logic [AW-1:0] addr, input logic [LW-1:0] rdata,
                             input int delay);
        logic [TW-1:0] t;
        int            idx;
        t   = addr[AW-1:4];
        idx = model_find(t);
        req_valid = 1'b1;
        req_addr  = addr;
        chk("lk_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lk_t1_quiet", {resp_valid, req_ready, pmem_read}, 0);
        @(negedge clk);
        if (idx >= 0) begin
            chk("hit_resp", {resp_valid, resp_hit, resp_dirty, pmem_read}, {1'b1, 1'b1, m_dirty[idx], 1'b0});
            chk("hit_data", resp_data, m_data[idx]);
            m_valid[idx] = 1'b0;
        end else begin
            chk("miss_read", {resp_valid, pmem_read, pmem_write}, 3'b010);
            chk("miss_address", pmem_address, {t, 4'h0});
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                chk("miss_hold", {pmem_read, resp_valid}, 2'b10);
            end
            pmem_resp  = 1'b1;
            pmem_rdata = rdata;
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = rnd_line();
            chk("miss_resp", {resp_valid, resp_hit, resp_dirty, pmem_read}, 4'b1000);
            chk("miss_data", resp_data, rdata);
        end
        @(negedge clk);
        chk("lk_done", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [LW-1:0] line_a;
        reset_n     = 1'b0;
        evict_valid = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        evict_dirty = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        model_reset();

        do_reset();
        do_lookup(16'h1230, rnd_line(), 2);

        line_a = rnd_line();
        do_evict(16'h4000, line_a, 1'b1, 0);
        do_lookup(16'h4008, rnd_line(), 0);
        do_lookup(16'h4008, rnd_line(), 1);

        do_reset();
        for (int i = 1; i <= 4; i++) do_evict(AW'(i * 16'h1000), rnd_line(), 1'b0, 0);
        do_evict(16'h5000, rnd_line(), 1'b0, 0);
        do_lookup(16'h1000, rnd_line(), 0);

        do_reset();
        do_evict(16'h1000, rnd_line(), 1'b1, 0);
        for (int i = 2; i <= 4; i++) do_evict(AW'(i * 16'h1000), rnd_line(), 1'b0, 0);
        do_evict(16'h5000, rnd_line(), 1'b0, 5);

        // Evict and lookup presented together on the same line.
        do_reset();
        line_a = rnd_line();
        @(negedge clk);
        evict_valid = 1'b1; evict_addr = 16'h6000; evict_data = line_a; evict_dirty = 1'b0;
        req_valid   = 1'b1; req_addr   = 16'h6004;
        @(negedge clk);
        evict_valid = 1'b0;
        chk("same_cycle_insert", {evict_ready, req_ready, pmem_read}, 0);
        @(negedge clk);
        chk("same_cycle_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("same_cycle_hit", {resp_valid, resp_hit, resp_dirty}, 3'b110);
        chk("same_cycle_data", resp_data, line_a);
        @(negedge clk);

        // Reset while a fetch is outstanding.
        do_reset();
        do_evict(16'h8000, rnd_line(), 1'b1, 0);
        do_evict(16'h9000, rnd_line(), 1'b0, 0);
        req_valid = 1'b1; req_addr = 16'hA000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("fetch_before_rst", pmem_read, 1);
        #2 reset_n = 1'b0;
        #1 chk("fetch_rst_drop", {pmem_read, pmem_write, resp_valid}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
        do_lookup(16'h8000, rnd_line(), 0);
        do_lookup(16'h9000, rnd_line(), 1);

        // Random traffic over a small tag pool to exercise hits, merges and replacement.
        for (int it = 0; it < 300; it++) begin
            logic [AW-1:0] a;
            a = {TW'(12'h100 + $urandom_range(0, 5)), 4'($urandom)};
            if ($urandom_range(0, 1) == 0)
                do_evict(a, rnd_line(), 1'($urandom), int'($urandom_range(0, 3)));
            else
                do_lookup(a, rnd_line(), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
